register_write_arbiter: RTL and testbench

Shares the single write path into the register bank (N-bit reset-able latch registers) between several requesters, e.g. ALU result, load unit and control unit. Grants one requester at a time, round-robin. Sequences each write as setup, strobe and hold phases, so data is stable around the level-sensitive write enable of the target register. Drives a one-hot write strobe per register plus a shared data bus.

---
 rtl/register_write_arbiter_if.sv | 41 ++++
 rtl/register_write_arbiter.sv | 136 +++++++++++++
 tb/tb_register_write_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/register_write_arbiter_if.sv
// register_write_arbiter_if
//   Write-path bundle between the requesters and the register write arbiter.
//   Parameters must match the arbiter instance: REQ requesters, W data bits,
//   A address bits (2**A registers).
//   Signals:
//     req_valid [REQ]    per-requester write request (level)
//     req_addr  [REQ*A]  packed addresses, requester i at [i*A +: A]
//     req_data  [REQ*W]  packed data, requester i at [i*W +: W]
//     req_ready [REQ]    one-cycle completion pulse to the granted requester
//     wr_en     [2**A]   one-hot register write strobes
//     wr_data   [W]      shared register data bus
//     grant_id           current owner, meaningful while busy
//     busy               arbiter is sequencing a write
//   Modports: master = requester side, slave = arbiter side.
interface register_write_arbiter_if #(
  parameter int REQ = 4,
  parameter int W   = 3,
  parameter int A   = 3
) ();
  localparam int ID_W = $clog2(REQ);
  localparam int NREG = 1 << A;

  logic [REQ-1:0]   req_valid;
  logic [REQ*A-1:0] req_addr;
  logic [REQ*W-1:0] req_data;
  logic [REQ-1:0]   req_ready;
  logic [NREG-1:0]  wr_en;
  logic [W-1:0]     wr_data;
  logic [ID_W-1:0]  grant_id;
  logic             busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_data, grant_id, busy
  );
endinterface

// File: rtl/register_write_arbiter.sv
// register_write_arbiter
//   Shares the single write path of a latch-based register bank between REQ
//   requesters. One requester is granted at a time (round-robin) and each
//   write is sequenced SETUP -> STROBE -> HOLD so wr_data is stable before,
//   during and after the level-sensitive write enable.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    register_write_arbiter_if.slave (requests in, strobes/data out)
//   All outputs are registered.
//   Optional build macro REGWR_ARB_FIXED_PRIO_EN: requester 0 always wins
//   when valid; the others share round-robin, and rr_ptr only advances on
//   their grants.
module register_write_arbiter #(
  parameter int REQ = 4,
  parameter int W   = 3,
  parameter int A   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  register_write_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(REQ);
  localparam int NREG = 1 << A;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] winner;
  logic [A-1:0]    cap_addr, cap_addr_nxt;
  logic [W-1:0]    wr_data_q, wr_data_nxt;
  logic [NREG-1:0] wr_en_q, wr_en_nxt;
  logic [REQ-1:0]  ready_q, ready_nxt;
  logic [ID_W-1:0] grant_q, grant_nxt;
  logic            busy_q, busy_nxt;
  logic            found;

  // (base + k) mod REQ, for k in 0..REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ) s = s - REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < REQ; k++) begin
      if (!found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_add(rr_ptr, k);
      end
    end
`ifdef REGWR_ARB_FIXED_PRIO_EN
    if (bus.req_valid[0]) winner = '0;
`else
`endif
  end

  // Next state and next registered outputs. wr_data_q doubles as the
  // captured data register; grant_q doubles as the captured winner.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    cap_addr_nxt = cap_addr;
    wr_data_nxt  = wr_data_q;
    grant_nxt    = grant_q;
    busy_nxt     = busy_q;
    wr_en_nxt    = '0;
    ready_nxt    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = SETUP;
          busy_nxt  = 1'b1;
          grant_nxt = winner;
          for (int i = 0; i < REQ; i++) begin
            if (ID_W'(i) == winner) begin
              wr_data_nxt  = bus.req_data[i*W +: W];
              cap_addr_nxt = bus.req_addr[i*A +: A];
            end
          end
        end
      end
      SETUP: begin
        state_nxt           = STROBE;
        wr_en_nxt[cap_addr] = 1'b1;
      end
      STROBE: begin
        state_nxt          = HOLD;
        ready_nxt[grant_q] = 1'b1;
      end
      HOLD: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
`ifdef REGWR_ARB_FIXED_PRIO_EN
        if (grant_q != '0) rr_ptr_nxt = wrap_add(grant_q, 1);
`else
        rr_ptr_nxt = wrap_add(grant_q, 1);
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_addr  <= '0;
      wr_data_q <= '0;
      wr_en_q   <= '0;
      ready_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cap_addr  <= cap_addr_nxt;
      wr_data_q <= wr_data_nxt;
      wr_en_q   <= wr_en_nxt;
      ready_q   <= ready_nxt;
      grant_q   <= grant_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.req_ready = ready_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter
//   Directed bench: stimulus pushes expected writes {id, addr, data} into a
//   queue; a monitor on the falling edge checks every strobe against the
//   queue head and pops/checks on every req_ready pulse. A small register
//   bank model latches wr_data while a strobe is high.
module tb_register_write_arbiter;
  localparam int REQ = 4, W = 3, A = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_write_arbiter_if #(.REQ(REQ), .W(W), .A(A)) bus ();

  register_write_arbiter #(.REQ(REQ), .W(W), .A(A)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int id; int addr; int data; } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W-1:0] bank [1<<A];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    for (int i = 0; i < (1<<A); i++)
      if (bus.wr_en[i] === 1'b1) bank[i] <= bus.wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en != '0) begin
        if (q.size() == 0) chk("unexpected_strobe", 32'(bus.wr_en), 32'h0);
        else begin
          chk("strobe_onehot", 32'(bus.wr_en), 32'(1) << q[0].addr);
          chk("strobe_data", 32'(bus.wr_data), 32'(q[0].data));
          chk("strobe_grant", 32'(bus.grant_id), 32'(q[0].id));
        end
      end
      if (bus.req_ready != '0) begin
        if (q.size() == 0) chk("unexpected_ready", 32'(bus.req_ready), 32'h0);
        else begin
          chk("ready_id", 32'(bus.req_ready), 32'(1) << q[0].id);
          chk("hold_data", 32'(bus.wr_data), 32'(q[0].data));
          chk("hold_wr_en", 32'(bus.wr_en), 32'h0);
          chk("bank_value", 32'(bank[q[0].addr]), 32'(q[0].data));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic set_req(input int i, input int addr, input int data);
    bus.req_addr[i*A +: A] = A'(addr);
    bus.req_data[i*W +: W] = W'(data);
  endtask

  task automatic push(input int id, input int addr, input int data);
    exp_t e;
    e.id = id; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns at #1 after the edge that raised req_ready.
  task automatic wait_ready(output int at);
    bit ok;
    ok = 0; at = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.req_ready != '0) begin ok = 1; at = cyc; break; end
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  int rr_ids[5];
  int fp_ids[4];
  int t, last;

  initial begin
    for (int i = 0; i < (1<<A); i++) bank[i] = '0;
`ifdef REGWR_ARB_FIXED_PRIO_EN
    rr_ids = '{0, 0, 0, 0, 0};
    fp_ids = '{0, 0, 0, 0};
`else
    rr_ids = '{0, 1, 2, 3, 0};
    fp_ids = '{0, 1, 0, 1};
`endif
    // Reset held 2 cycles with every requester valid
    reset = 1'b1;
    bus.req_valid = '1;
    set_req(0, 1, 1); set_req(1, 2, 2); set_req(2, 3, 4); set_req(3, 6, 7);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_grant", 32'(bus.grant_id), 32'h0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'h0);
    end
    // Round-robin with all requesters continuously valid
    for (int j = 0; j < 5; j++) begin
      case (rr_ids[j])
        0: push(0, 1, 1);
        1: push(1, 2, 2);
        2: push(2, 3, 4);
        default: push(3, 6, 7);
      endcase
    end
    reset = 1'b0;
    last = 0;
    for (int j = 0; j < 5; j++) begin
      wait_ready(t);
      if (j > 0) chk("rr_spacing", 32'(t - last), 32'd4);
      last = t;
      tick();
    end
    bus.req_valid = '0;

    // Single write: req0 addr 5 data 101
    set_req(0, 5, 5);
    bus.req_valid = 4'b0001;
    push(0, 5, 5);
    tick();
    chk("setup_wr_data", 32'(bus.wr_data), 32'h5);
    chk("setup_wr_en", 32'(bus.wr_en), 32'h0);
    chk("setup_busy", 32'(bus.busy), 32'h1);
    chk("setup_grant", 32'(bus.grant_id), 32'h0);
    tick();
    chk("strobe_wr_en", 32'(bus.wr_en), 32'h20);
    tick();
    chk("hold_wr_en_d", 32'(bus.wr_en), 32'h0);
    chk("hold_ready_d", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;

    // Stability: req2 data changes 3 -> 6 during STROBE
    set_req(2, 3, 3);
    bus.req_valid = 4'b0100;
    push(2, 3, 3);
    tick(); tick();
    set_req(2, 3, 6);
    wait_ready(t);
    tick();
    bus.req_valid = '0;

    // Reset during STROBE (rr_ptr is 3 here)
    set_req(1, 7, 2);
    bus.req_valid = 4'b0010;
    push(1, 7, 2);
    tick(); tick();
    chk("abort_strobe", 32'(bus.wr_en), 32'h80);
    reset = 1'b1;
    tick();
    chk("abort_wr_en", 32'(bus.wr_en), 32'h0);
    chk("abort_ready", 32'(bus.req_ready), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    q.delete();
    reset = 1'b0;
    // rr_ptr back at 0: req1 wins over req3; then req3 drops valid early
    set_req(1, 7, 2);
    set_req(3, 4, 6);
    bus.req_valid = 4'b1010;
    push(1, 7, 2);
    push(3, 4, 6);
    wait_ready(t);
    tick();
    bus.req_valid = 4'b1000;
    tick();
    chk("early_setup_grant", 32'(bus.grant_id), 32'h3);
    bus.req_valid = '0;
    set_req(3, 4, 1);
    wait_ready(t);
    tick();

    // req0 and req1 continuously valid
    set_req(0, 0, 3);
    set_req(1, 2, 5);
    for (int j = 0; j < 4; j++) begin
      if (fp_ids[j] == 0) push(0, 0, 3);
      else push(1, 2, 5);
    end
    bus.req_valid = 4'b0011;
    for (int j = 0; j < 4; j++) begin
      wait_ready(t);
      tick();
    end
    bus.req_valid = '0;

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
